// File: rtl/squash_unit_l2_reg.sv
// squash_unit_l2_reg: single-entry holding register for the oldest outstanding
// squash. Captures the arbitrated squash from the L1 chain and offers it to
// fetch with a val/rdy handshake. Age is measured against an in-order commit
// head counter.
module squash_unit_l2_reg #(
  parameter int p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arb_val,
  input  logic [p_seq_num_bits-1:0] arb_seq_num,
  input  logic [31:0]               arb_target,
  input  logic                      commit_val,
  output logic                      squash_val,
  output logic [p_seq_num_bits-1:0] squash_seq_num,
  output logic [31:0]               squash_target,
  input  logic                      squash_rdy,
  output logic                      pend_older_drop
);

  logic                      pend_val_q, pend_val_d;
  logic [p_seq_num_bits-1:0] pend_seq_q, pend_seq_d;
  logic [31:0]               pend_target_q, pend_target_d;
  logic [p_seq_num_bits-1:0] head_q, head_d;
  logic                      drop_q, drop_d;

  logic [p_seq_num_bits-1:0] arb_age;
  logic [p_seq_num_bits-1:0] pend_age;
  logic                      arb_older;
  logic                      fire;

  // Ages relative to the pre-update head; modular subtraction handles wrap.
  assign arb_age   = arb_seq_num - head_q;
  assign pend_age  = pend_seq_q - head_q;
  assign arb_older = (arb_age < pend_age);
  assign fire      = pend_val_q & squash_rdy;

  // Next-state selection for the pending entry and the drop pulse.
  always_comb begin
    pend_val_d    = pend_val_q;
    pend_seq_d    = pend_seq_q;
    pend_target_d = pend_target_q;
    drop_d        = 1'b0;
    head_d        = head_q + {{(p_seq_num_bits-1){1'b0}}, commit_val};
    if (arb_val) begin
      if (!pend_val_q || arb_older) begin
        // An older squash supersedes the pending one even if it fires now.
        pend_val_d    = 1'b1;
        pend_seq_d    = arb_seq_num;
        pend_target_d = arb_target;
      end else begin
        // Younger/equal arb is already covered by the pending squash.
        drop_d = 1'b1;
        if (fire) pend_val_d = 1'b0;
      end
    end else if (fire) begin
      pend_val_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val_q    <= 1'b0;
      pend_seq_q    <= '0;
      pend_target_q <= '0;
      head_q        <= '0;
      drop_q        <= 1'b0;
    end else begin
      pend_val_q    <= pend_val_d;
      pend_seq_q    <= pend_seq_d;
      pend_target_q <= pend_target_d;
      head_q        <= head_d;
      drop_q        <= drop_d;
    end
  end

  assign squash_val      = pend_val_q;
  assign squash_seq_num  = pend_seq_q;
  assign squash_target   = pend_target_q;
  assign pend_older_drop = drop_q;

endmodule

// File: tb/tb_squash_unit_l2_reg.sv
// Testbench for squash_unit_l2_reg: directed vector table, hand-written
// wrap-around sequence, and randomized traffic against a behavioural model.
module tb_squash_unit_l2_reg;

  localparam int NB  = 5;
  localparam int MOD = 1 << NB;

  logic            clk = 1'b0;
  logic            rst;
  logic            arb_val;
  logic [NB-1:0]   arb_seq_num;
  logic [31:0]     arb_target;
  logic            commit_val;
  logic            squash_val;
  logic [NB-1:0]   squash_seq_num;
  logic [31:0]     squash_target;
  logic            squash_rdy;
  logic            pend_older_drop;

  squash_unit_l2_reg #(.p_seq_num_bits(NB)) dut (
    .clk            (clk),
    .rst            (rst),
    .arb_val        (arb_val),
    .arb_seq_num    (arb_seq_num),
    .arb_target     (arb_target),
    .commit_val     (commit_val),
    .squash_val     (squash_val),
    .squash_seq_num (squash_seq_num),
    .squash_target  (squash_target),
    .squash_rdy     (squash_rdy),
    .pend_older_drop(pend_older_drop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: one pending squash, ages as plain modular distances.
  int          m_head;
  bit          m_val;
  int          m_seq;
  logic [31:0] m_tgt;
  bit          m_drop;

  function automatic int age(int x);
    return ((x - m_head) % MOD + MOD) % MOD;
  endfunction

  function automatic string trace(int level, bit v, int s, logic [31:0] t);
    if (level > 0) return v ? $sformatf("%02d:%08h", s, t) : "           ";
    return v ? $sformatf("%02d", s) : "  ";
  endfunction

  task automatic model_step(bit r, bit a, int s, logic [31:0] t, bit c, bit rdy);
    bit fire;
    if (r) begin
      m_head = 0; m_val = 0; m_seq = 0; m_tgt = '0; m_drop = 0;
      return;
    end
    fire   = m_val && rdy;
    m_drop = 0;
    if (a && (!m_val || age(s) < age(m_seq))) begin
      m_val = 1; m_seq = s; m_tgt = t;
    end else if (a) begin
      m_drop = 1;
      if (fire) m_val = 0;
    end else if (fire) begin
      m_val = 0;
    end
    m_head = (m_head + int'(c)) % MOD;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (out=[%s])", name, act, exp,
               trace(1, squash_val, int'(squash_seq_num), squash_target));
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic cycle(bit r, bit a, int s, logic [31:0] t, bit c, bit rdy);
    rst = r; arb_val = a; arb_seq_num = NB'(s); arb_target = t;
    commit_val = c; squash_rdy = rdy;
    model_step(r, a, s, t, c, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".val"},  32'(squash_val),      32'(m_val));
    chk({tag, ".seq"},  32'(squash_seq_num),  32'(m_seq));
    chk({tag, ".tgt"},  squash_target,        m_tgt);
    chk({tag, ".drop"}, 32'(pend_older_drop), 32'(m_drop));
  endtask

  typedef struct {
    bit          r, a;
    int          s;
    logic [31:0] t;
    bit          c, rdy;
    bit          ev;
    int          es;
    logic [31:0] et;
    bit          ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit a, int s, logic [31:0] t, bit c, bit rdy,
                              bit ev, int es, logic [31:0] et, bit ed);
    vec_t v;
    v.r = r; v.a = a; v.s = s; v.t = t; v.c = c; v.rdy = rdy;
    v.ev = ev; v.es = es; v.et = et; v.ed = ed;
    return v;
  endfunction

  initial begin
    rst = 1; arb_val = 0; arb_seq_num = '0; arb_target = '0;
    commit_val = 0; squash_rdy = 0;

    // Reset then idle
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0));
    // Basic capture and handshake
    tbl.push_back(mk(0,1,3,32'h200,0,0, 1,3,32'h200,0));
    tbl.push_back(mk(0,0,0,0,0,0,       1,3,32'h200,0));
    tbl.push_back(mk(0,0,0,0,0,0,       1,3,32'h200,0));
    tbl.push_back(mk(0,0,0,0,0,1,       0,3,32'h200,0));
    // Older replacement, then younger drop
    tbl.push_back(mk(0,1,6,32'h60,0,0,  1,6,32'h60,0));
    tbl.push_back(mk(0,1,2,32'h80,0,0,  1,2,32'h80,0));
    tbl.push_back(mk(0,1,9,32'h90,0,0,  1,2,32'h80,1));
    tbl.push_back(mk(0,0,0,0,0,0,       1,2,32'h80,0));
    tbl.push_back(mk(0,0,0,0,0,1,       0,2,32'h80,0));
    // Simultaneous fire + arb
    tbl.push_back(mk(0,1,4,32'h40,0,0,  1,4,32'h40,0));
    tbl.push_back(mk(0,1,7,32'h70,0,1,  0,4,32'h40,1));
    tbl.push_back(mk(0,1,4,32'h44,0,0,  1,4,32'h44,0));
    tbl.push_back(mk(0,1,1,32'h10,0,1,  1,1,32'h10,0));
    tbl.push_back(mk(0,0,0,0,0,1,       0,1,32'h10,0));
    // Equal age is not older
    tbl.push_back(mk(0,1,5,32'h50,0,0,  1,5,32'h50,0));
    tbl.push_back(mk(0,1,5,32'h55,0,0,  1,5,32'h50,1));
    // Reset mid-hold overrides a concurrent arb
    tbl.push_back(mk(1,1,1,32'h11,1,0,  0,0,0,0));
    tbl.push_back(mk(0,1,0,32'hABC,0,0, 1,0,32'hABC,0));
    tbl.push_back(mk(0,0,0,0,0,1,       0,0,32'hABC,0));

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].a, tbl[i].s, tbl[i].t, tbl[i].c, tbl[i].rdy);
      chk($sformatf("vec%0d.val", i),  32'(squash_val),      32'(tbl[i].ev));
      chk($sformatf("vec%0d.seq", i),  32'(squash_seq_num),  32'(tbl[i].es));
      chk($sformatf("vec%0d.tgt", i),  squash_target,        tbl[i].et);
      chk($sformatf("vec%0d.drop", i), 32'(pend_older_drop), 32'(tbl[i].ed));
    end

    // Wrap-around ages: move head to 24 via commits
    cycle(1,0,0,0,0,0);
    for (int i = 0; i < 24; i++) cycle(0,0,0,0,1,0);
    cycle(0,1,30,32'h300,0,0);
    chk("wrap.cap", 32'(squash_seq_num), 32'd30);
    cycle(0,1,1,32'h301,0,0);                 // age 9 vs 6: dropped
    chk("wrap.hold.seq", 32'(squash_seq_num), 32'd30);
    chk("wrap.hold.drop", 32'(pend_older_drop), 32'd1);
    cycle(0,1,26,32'h302,0,0);                // age 2 vs 6: replaces
    chk("wrap.repl.seq", 32'(squash_seq_num), 32'd26);
    chk("wrap.repl.tgt", squash_target, 32'h302);
    // Pre-update head on a commit cycle: pend at head (age 0) vs head+5
    cycle(0,1,24,32'h303,0,0);                // age 0 replaces 26
    chk("head.cap", 32'(squash_seq_num), 32'd24);
    cycle(0,1,29,32'h304,1,0);                // age 5 vs 0 with commit: held
    chk("head.hold.seq", 32'(squash_seq_num), 32'd24);
    chk("head.hold.drop", 32'(pend_older_drop), 32'd1);
    cycle(0,1,30,32'h305,0,0);                // head 25: pend age 31 vs 5
    chk("head.repl.seq", 32'(squash_seq_num), 32'd30);
    chk_model("wrap.model");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(99) < 2), $urandom_range(1), int'($urandom_range(MOD-1)),
            $urandom, $urandom_range(1), $urandom_range(1));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
